stream_harness_bridge: RTL and testbench

Synthesizable byte-stream command interpreter that drives a device under test from a host link, replacing the behavioural file-I/O harness loop for FPGA-in-the-loop runs. Accepts single-byte commands plus operands on a valid/ready input stream, drives DUT inputs, DUT reset and a DUT clock enable, and returns captured DUT outputs on a valid/ready response stream. Generalises the harness with parametrised widths, atomic input update, multi-cycle step counts and explicit error reporting.

---
 rtl/stream_harness_bridge_if.sv | 19 +
 rtl/stream_harness_bridge.sv | 180 ++++++++++++++++++
 tb/tb_stream_harness_bridge.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_harness_bridge_if.sv
// Host link of the stream harness bridge: command byte stream in, response byte stream out.
interface stream_harness_bridge_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;

    modport master (
        output cmd_data, cmd_valid, rsp_ready,
        input  cmd_ready, rsp_data, rsp_valid
    );

    modport slave (
        input  cmd_data, cmd_valid, rsp_ready,
        output cmd_ready, rsp_data, rsp_valid
    );
endinterface

// File: rtl/stream_harness_bridge.sv
// Byte-stream command interpreter driving a DUT's inputs, reset and clock enable,
// and returning snapshots of its outputs over a response stream.
module stream_harness_bridge #(
    parameter int unsigned IN_WIDTH       = 32,
    parameter int unsigned OUT_WIDTH      = 32,
    parameter int unsigned STEP_CNT_BYTES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_harness_bridge_if.slave host,
    output logic [IN_WIDTH-1:0]  dut_in,
    input  logic [OUT_WIDTH-1:0] dut_out,
    output logic                 dut_rst,
    output logic                 dut_clk_en,
    output logic                 halted,
    output logic                 error
);
    localparam int unsigned IN_BYTES  = (IN_WIDTH + 7) / 8;
    localparam int unsigned OUT_BYTES = (OUT_WIDTH + 7) / 8;
    localparam int unsigned IN_PAD    = 8 * IN_BYTES;
    localparam int unsigned OUT_PAD   = 8 * OUT_BYTES;
    localparam int unsigned CNT_W     = 8 * STEP_CNT_BYTES;
    localparam int unsigned MAX_IO    = (IN_BYTES > OUT_BYTES) ? IN_BYTES : OUT_BYTES;
    localparam int unsigned MAX_BYTES = (MAX_IO > STEP_CNT_BYTES) ? MAX_IO : STEP_CNT_BYTES;
    localparam int unsigned IDX_W     = $clog2(MAX_BYTES + 1);

    localparam logic [7:0] CMD_SNAP    = 8'h68;
    localparam logic [7:0] CMD_HALT    = 8'h69;
    localparam logic [7:0] CMD_RST_ON  = 8'h6A;
    localparam logic [7:0] CMD_RST_OFF = 8'h6B;
    localparam logic [7:0] CMD_STEP    = 8'h6C;
    localparam logic [7:0] CMD_LOAD    = 8'h6D;
    localparam logic [7:0] ERR_BYTE    = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE, ST_GET_IN, ST_GET_CNT, ST_STEP, ST_SEND, ST_HALTED
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt, idx_inc;
    logic [IN_PAD-1:0]    stage, stage_nxt, in_word;
    logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_word;
    logic [OUT_PAD-1:0]   snap, snap_nxt, out_word;
    logic                 err_rsp, err_rsp_nxt;
    logic [IN_WIDTH-1:0]  dut_in_nxt;
    logic                 dut_rst_nxt, error_nxt;
    logic [7:0]           rsp_data_q, rsp_data_nxt;
    logic                 cmd_ready_q, rsp_valid_q;
    logic                 cmd_fire, rsp_fire;

    assign host.cmd_ready = cmd_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;

    assign cmd_fire = host.cmd_valid && cmd_ready_q;
    assign rsp_fire = rsp_valid_q && host.rsp_ready;
    assign idx_inc  = idx + IDX_W'(1);
    assign out_word = OUT_PAD'(dut_out);

    // State register plus registered outputs decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            stage       <= '0;
            cnt         <= '0;
            snap        <= '0;
            err_rsp     <= 1'b0;
            dut_in      <= '0;
            dut_rst     <= 1'b1;
            error       <= 1'b0;
            rsp_data_q  <= 8'h00;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            dut_clk_en  <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            stage       <= stage_nxt;
            cnt         <= cnt_nxt;
            snap        <= snap_nxt;
            err_rsp     <= err_rsp_nxt;
            dut_in      <= dut_in_nxt;
            dut_rst     <= dut_rst_nxt;
            error       <= error_nxt;
            rsp_data_q  <= rsp_data_nxt;
            cmd_ready_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_GET_IN) ||
                           (state_nxt == ST_GET_CNT);
            rsp_valid_q <= (state_nxt == ST_SEND);
            dut_clk_en  <= (state_nxt == ST_STEP);
            halted      <= (state_nxt == ST_HALTED);
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        stage_nxt    = stage;
        cnt_nxt      = cnt;
        snap_nxt     = snap;
        err_rsp_nxt  = err_rsp;
        dut_in_nxt   = dut_in;
        dut_rst_nxt  = dut_rst;
        error_nxt    = error;
        rsp_data_nxt = rsp_data_q;

        // Operand bytes land LSB first at the current byte index
        in_word                    = stage;
        in_word[{idx, 3'b000} +: 8] = host.cmd_data;
        cnt_word                    = cnt;
        cnt_word[{idx, 3'b000} +: 8] = host.cmd_data;

        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    idx_nxt = '0;
                    case (host.cmd_data)
                        CMD_SNAP: begin
                            snap_nxt     = out_word;
                            rsp_data_nxt = out_word[7:0];
                            err_rsp_nxt  = 1'b0;
                            state_nxt    = ST_SEND;
                        end
                        CMD_HALT:    state_nxt   = ST_HALTED;
                        CMD_RST_ON:  dut_rst_nxt = 1'b1;
                        CMD_RST_OFF: dut_rst_nxt = 1'b0;
                        CMD_STEP:    state_nxt   = ST_GET_CNT;
                        CMD_LOAD:    state_nxt   = ST_GET_IN;
                        default: begin
                            rsp_data_nxt = ERR_BYTE;
                            err_rsp_nxt  = 1'b1;
                            error_nxt    = 1'b1;
                            state_nxt    = ST_SEND;
                        end
                    endcase
                end
            end
            ST_GET_IN: begin
                if (cmd_fire) begin
                    stage_nxt = in_word;
                    if (idx == IDX_W'(IN_BYTES - 1)) begin
                        dut_in_nxt = IN_WIDTH'(in_word);
                        state_nxt  = ST_IDLE;
                    end else begin
                        idx_nxt = idx_inc;
                    end
                end
            end
            ST_GET_CNT: begin
                if (cmd_fire) begin
                    cnt_nxt = cnt_word;
                    if (idx == IDX_W'(STEP_CNT_BYTES - 1)) begin
                        state_nxt = (cnt_word == '0) ? ST_IDLE : ST_STEP;
                    end else begin
                        idx_nxt = idx_inc;
                    end
                end
            end
            ST_STEP: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nxt = ST_IDLE;
            end
            ST_SEND: begin
                if (rsp_fire) begin
                    if (err_rsp) begin
                        state_nxt = ST_HALTED;
                    end else if (idx == IDX_W'(OUT_BYTES - 1)) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt      = idx_inc;
                        rsp_data_nxt = snap[{idx_inc, 3'b000} +: 8];
                    end
                end
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_stream_harness_bridge.sv
// Scoreboard bench for stream_harness_bridge: expected response bytes are queued
// when a command is sent and matched as the bridge hands them over.
module tb_stream_harness_bridge;
    logic        clk;
    logic        rst;
    logic [31:0] dut_in;
    logic [31:0] dut_out;
    logic        dut_rst;
    logic        dut_clk_en;
    logic        halted;
    logic        error;

    stream_harness_bridge_if bus();

    stream_harness_bridge #(
        .IN_WIDTH(32), .OUT_WIDTH(32), .STEP_CNT_BYTES(2)
    ) u_dut (
        .clk(clk), .rst(rst), .host(bus),
        .dut_in(dut_in), .dut_out(dut_out), .dut_rst(dut_rst),
        .dut_clk_en(dut_clk_en), .halted(halted), .error(error)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rx_cnt = 0;
    int          en_cnt = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: toggle, 2: stalled
    logic [7:0]  exp_q[$];
    logic [31:0] fake_cnt;
    logic [31:0] fixed_out;
    logic        use_cnt;
    logic        held_valid;
    logic [7:0]  held_byte;

    // Stand-in DUT: a counter advanced by the bridge's clock enable
    always @(posedge clk) begin
        if (dut_rst) fake_cnt <= '0;
        else if (dut_clk_en) fake_cnt <= fake_cnt + 32'd1;
    end
    always_comb dut_out = use_cnt ? fake_cnt : fixed_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = ~bus.rsp_ready;
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // Response monitor: pop on handshake, verify bytes held while stalled
    always @(negedge clk) begin
        if (dut_clk_en) en_cnt++;
        if (!rst && bus.rsp_valid) begin
            if (held_valid) check("rsp_hold", bus.rsp_data, held_byte);
            held_valid = !bus.rsp_ready;
            held_byte  = bus.rsp_data;
            if (bus.rsp_ready) begin
                rx_cnt++;
                if (exp_q.size() == 0) check("rsp_unexpected", 32'(bus.rsp_data), 32'hFFFF_FFFF);
                else check("rsp_byte", bus.rsp_data, exp_q.pop_front());
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.cmd_data  = b;
        bus.cmd_valid = 1'b1;
        for (int n = 0; n < 300 && !bus.cmd_ready; n++) @(negedge clk);
        if (!bus.cmd_ready) begin
            check("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && (bus.cmd_ready || halted)) break;
        end
        if (n == 500) check("idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_rst();
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data), 32'd0);
        check("rst_dut_in",    dut_in, 32'd0);
        check("rst_dut_rst",   32'(dut_rst), 32'd1);
        check("rst_clk_en",    32'(dut_clk_en), 32'd0);
        check("rst_halted",    32'(halted), 32'd0);
        check("rst_error",     32'(error), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        use_cnt   = 1'b1;
        fixed_out = 32'h0;
        held_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_dut_rst",   32'(dut_rst), 32'd1);
        check("reset_dut_in",    dut_in, 32'd0);
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_data",  32'(bus.rsp_data), 32'd0);
        check("reset_halted",    32'(halted), 32'd0);
        check("reset_error",     32'(error), 32'd0);
        check("reset_clk_en",    32'(dut_clk_en), 32'd0);
        @(posedge clk); #1;

        // DUT reset control with back-to-back commands
        send_byte(8'h6B);
        check("rst_off", 32'(dut_rst), 32'd0);
        send_byte(8'h6A);
        check("rst_on", 32'(dut_rst), 32'd1);
        check("rst_on_ready", 32'(bus.cmd_ready), 32'd1);
        send_byte(8'h6B);
        check("rst_off2", 32'(dut_rst), 32'd0);

        // Atomic input load
        send_byte(8'h6D);
        send_byte(8'h78); check("load_hold0", dut_in, 32'd0);
        send_byte(8'h56); check("load_hold1", dut_in, 32'd0);
        send_byte(8'h34); check("load_hold2", dut_in, 32'd0);
        send_byte(8'h12); check("load_done",  dut_in, 32'h1234_5678);
        send_byte(8'h6D);
        send_byte(8'hEF); check("reload_hold0", dut_in, 32'h1234_5678);
        send_byte(8'hBE); check("reload_hold1", dut_in, 32'h1234_5678);
        send_byte(8'hAD); check("reload_hold2", dut_in, 32'h1234_5678);
        send_byte(8'hDE); check("reload_done",  dut_in, 32'hDEAD_BEEF);

        // Step by 3, then by 0
        en_cnt = 0;
        send_byte(8'h6C);
        send_byte(8'h03);
        send_byte(8'h00);
        @(negedge clk);
        check("step_en_first",  32'(dut_clk_en), 32'd1);
        check("step_busy",      32'(bus.cmd_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("step_en_last",   32'(dut_clk_en), 32'd1);
        @(negedge clk);
        check("step_en_off",    32'(dut_clk_en), 32'd0);
        check("step_ready_back", 32'(bus.cmd_ready), 32'd1);
        check("step_en_count",  32'(en_cnt), 32'd3);
        check("step_dut_count", fake_cnt, 32'd3);
        @(posedge clk); #1;
        en_cnt = 0;
        send_byte(8'h6C);
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        check("step0_ready", 32'(bus.cmd_ready), 32'd1);
        check("step0_en",    32'(dut_clk_en), 32'd0);
        repeat (3) @(negedge clk);
        check("step0_count", 32'(en_cnt), 32'd0);
        @(posedge clk); #1;

        // Snapshot of the stand-in counter
        push_word(32'd3);
        send_byte(8'h68);
        wait_idle();
        @(posedge clk); #1;

        // Snapshot with toggling rsp_ready
        use_cnt   = 1'b0;
        fixed_out = 32'hCAFE_BABE;
        rdy_mode  = 1;
        rx0 = rx_cnt;
        push_word(32'hCAFE_BABE);
        send_byte(8'h68);
        fixed_out = 32'h0000_0000;
        wait_idle();
        check("snap_rx_count", 32'(rx_cnt - rx0), 32'd4);
        rdy_mode = 0;
        @(posedge clk); #1;

        // Reset in the middle of operands
        send_byte(8'h6D);
        send_byte(8'hAA);
        send_byte(8'hBB);
        pulse_rst();
        send_byte(8'h6D);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check("post_rst_load", dut_in, 32'h0403_0201);

        // Reset while a response is stalled
        rdy_mode  = 2;
        fixed_out = 32'h1122_3344;
        push_word(32'h1122_3344);
        send_byte(8'h68);
        repeat (3) @(negedge clk);
        check("stall_valid", 32'(bus.rsp_valid), 32'd1);
        check("stall_byte0", 32'(bus.rsp_data), 32'h44);
        pulse_rst();
        rdy_mode  = 0;
        fixed_out = 32'h0BAD_F00D;
        rx0 = rx_cnt;
        push_word(32'h0BAD_F00D);
        send_byte(8'h68);
        wait_idle();
        check("fresh_rx_count", 32'(rx_cnt - rx0), 32'd4);
        @(posedge clk); #1;

        // Explicit halt
        send_byte(8'h69);
        @(negedge clk);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_ready",  32'(bus.cmd_ready), 32'd0);
        pulse_rst();

        // Unknown command
        rdy_mode = 2;
        exp_q.push_back(8'hEE);
        send_byte(8'h41);
        @(negedge clk);
        check("err_sticky",     32'(error), 32'd1);
        check("err_not_halted", 32'(halted), 32'd0);
        check("err_rsp_valid",  32'(bus.rsp_valid), 32'd1);
        rdy_mode = 1;
        wait_idle();
        @(negedge clk);
        check("err_halted",   32'(halted), 32'd1);
        check("err_ready",    32'(bus.cmd_ready), 32'd0);
        check("err_rsp_off",  32'(bus.rsp_valid), 32'd0);
        check("err_q_empty",  32'(exp_q.size()), 32'd0);
        bus.cmd_data  = 8'h6B;
        bus.cmd_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("halt_ignores_cmd", 32'(dut_rst), 32'd1);
        check("halt_ready_stuck", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b0;
        rdy_mode = 0;
        pulse_rst();
        check("err_cleared", 32'(error), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
